// File: rtl/msx_mouse_reader.sv
// MSX joystick-port mouse reader: strobes out four nibbles per frame
// and presents X/Y displacement plus button state with a valid pulse.
module msx_mouse_reader #(
    parameter int WAIT_CYC = 64,
    parameter int GAP_CYC  = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] data_in,
    output logic       strobe,
    output logic       busy,
    output logic       valid,
    output logic [7:0] dx,
    output logic [7:0] dy,
    output logic [1:0] btn
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] EDGE   = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] GAP    = 3'd4;

    localparam logic [15:0] WAIT_LD = 16'(WAIT_CYC - 1);
    localparam logic [15:0] GAP_LD  = 16'(GAP_CYC);

    logic [2:0]  state;
    logic [1:0]  idx;
    logic [15:0] cnt;
    logic [5:0]  sync1;
    logic [5:0]  sync2;
    logic [11:0] nib_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= data_in;
            sync2 <= sync1;
        end
    end

    // SAMPLE spends two cycles: capture (cnt!=0), then advance idx.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= 2'd0;
            cnt    <= 16'd0;
            strobe <= 1'b0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            dx     <= 8'd0;
            dy     <= 8'd0;
            btn    <= 2'd0;
            nib_sh <= 12'd0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= EDGE;
                        idx   <= 2'd0;
                        busy  <= 1'b1;
                    end
                end
                EDGE: begin
                    strobe <= ~strobe;
                    cnt    <= WAIT_LD;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cnt == 16'd1) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                SAMPLE: begin
                    if (cnt != 16'd0) begin
                        if (idx == 2'd3) begin
                            dx     <= nib_sh[11:4];
                            dy     <= {nib_sh[3:0], sync2[3:0]};
                            btn    <= ~sync2[5:4];
                            valid  <= 1'b1;
                            strobe <= 1'b0;
                            cnt    <= GAP_LD;
                            state  <= GAP;
                        end else begin
                            nib_sh <= {nib_sh[7:0], sync2[3:0]};
                            cnt    <= 16'd0;
                        end
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= EDGE;
                    end
                end
                GAP: begin
                    strobe <= 1'b0;
                    if (cnt == 16'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msx_mouse_reader.sv
// Bench for msx_mouse_reader: strobe-driven mouse model, expected
// frames queued per instance and checked by a valid-driven monitor.
module tb_msx_mouse_reader;

    localparam int W0 = 64;
    localparam int G0 = 16;
    localparam int W1 = 3;
    localparam int G1 = 1;

    typedef struct {
        logic [7:0] dx;
        logic [7:0] dy;
        logic [1:0] btn;
        longint     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] start;
    logic [1:0][5:0] din;
    wire  [1:0] strobe;
    wire  [1:0] busy;
    wire  [1:0] valid;
    wire  [1:0][7:0] dx;
    wire  [1:0][7:0] dy;
    wire  [1:0][1:0] btn;

    int errors = 0;
    int checks = 0;
    longint cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    int wc[2];
    int gc[2];

    msx_mouse_reader #(.WAIT_CYC(W0), .GAP_CYC(G0)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .data_in(din[0]),
        .strobe(strobe[0]), .busy(busy[0]), .valid(valid[0]),
        .dx(dx[0]), .dy(dy[0]), .btn(btn[0])
    );

    msx_mouse_reader #(.WAIT_CYC(W1), .GAP_CYC(G1)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .data_in(din[1]),
        .strobe(strobe[1]), .busy(busy[1]), .valid(valid[1]),
        .dx(dx[1]), .dy(dy[1]), .btn(btn[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic mon_step(input int s);
        exp_t e;
        int   sz;
        if (valid[s] === 1'b1) begin
            sz = (s == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid dut%0d: got valid, expected none (cycle %0d)",
                         s, cyc);
            end else begin
                if (s == 0) e = q0.pop_front();
                else e = q1.pop_front();
                chk($sformatf("dx_dut%0d", s), dx[s], e.dx);
                chk($sformatf("dy_dut%0d", s), dy[s], e.dy);
                chk($sformatf("btn_dut%0d", s), btn[s], e.btn);
                chk($sformatf("valid_cycle_dut%0d", s), cyc, e.cyc);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon_step(0);
            mon_step(1);
        end
    end

    task automatic frame(input int s, input logic [15:0] nibs,
                         input logic [1:0] bt, input bit rk,
                         input bit issue, input bit held, input bit poke,
                         input bit abort, input longint exp_in,
                         output longint exp_out);
        logic [3:0] nw[4];
        logic [3:0] od[4];
        logic [3:0] cap[4];
        int k[4];
        int w;
        int g;
        int hi;
        longint c0;
        logic prev;
        bit seen;
        exp_t e;
        w = wc[s];
        g = gc[s];
        for (int i = 0; i < 4; i++) begin
            nw[i] = nibs[15-4*i -: 4];
            od[i] = nw[i] ^ 4'($urandom_range(1, 15));
            k[i] = 0;
            if (rk) begin
                if ($urandom_range(0, 2) == 0) k[i] = w - 1;
                else k[i] = int'($urandom_range(0, w - 3));
            end
            cap[i] = (k[i] <= w - 3) ? nw[i] : od[i];
        end
        exp_out = issue ? cyc + 4 * (w + 2) : exp_in;
        c0 = exp_out - 4 * (w + 2);
        e.dx = {cap[0], cap[1]};
        e.dy = {cap[2], cap[3]};
        e.btn = ~bt;
        e.cyc = exp_out;
        if (!abort) begin
            if (s == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        if (issue) begin
            start[s] = 1'b1;
            @(posedge clk);
            #1;
            if (!held) start[s] = 1'b0;
        end
        prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = 1'b0;
            for (int n = 0; n < w + 4 && !seen; n++) begin
                @(posedge clk);
                #1;
                if (strobe[s] !== prev) seen = 1'b1;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL strobe_edge_timeout dut%0d edge %0d: got no edge, expected one",
                         s, i);
                start[s] = 1'b0;
                return;
            end
            prev = strobe[s];
            chk($sformatf("strobe_level_dut%0d_e%0d", s, i), strobe[s],
                (i % 2 == 0) ? 1 : 0);
            chk($sformatf("strobe_edge_cycle_dut%0d_e%0d", s, i), cyc,
                c0 + 2 + i * (w + 2));
            if (abort && i == 2) begin
                #2;
                reset = 1'b1;
                #1;
                chk("abort_strobe", strobe[s], 0);
                chk("abort_busy", busy[s], 0);
                chk("abort_valid", valid[s], 0);
                chk("abort_dx", dx[s], 0);
                chk("abort_dy", dy[s], 0);
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                chk("abort_strobe_held", strobe[s], 0);
                reset = 1'b0;
                return;
            end
            din[s] = {bt, od[i]};
            if (poke && i == 1) start[s] = 1'b1;
            for (int j = 0; j < k[i]; j++) begin
                @(posedge clk);
                #1;
                if (poke) start[s] = 1'b0;
            end
            din[s] = {bt, nw[i]};
            if (poke && i == 1 && start[s]) begin
                @(posedge clk);
                #1;
                start[s] = 1'b0;
            end
        end
        hi = 0;
        for (int j = 0; j < 4 * (w + 2) + g + 20 && busy[s] === 1'b1; j++) begin
            @(posedge clk);
            #1;
            if (poke) start[s] = 1'b0;
            if (poke && cyc == exp_out + 1) start[s] = 1'b1;
            if (strobe[s] !== 1'b0) hi++;
        end
        if (!held) start[s] = 1'b0;
        chk($sformatf("busy_fall_dut%0d", s), busy[s], 0);
        chk($sformatf("gap_end_cycle_dut%0d", s), cyc, exp_out + g + 1);
        chk($sformatf("gap_strobe_low_dut%0d", s), hi, 0);
        if (!held) begin
            hi = 0;
            for (int j = 0; j < 3; j++) begin
                @(posedge clk);
                #1;
                if (busy[s] !== 1'b0 || strobe[s] !== 1'b0) hi++;
            end
            chk($sformatf("idle_after_gap_dut%0d", s), hi, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        longint ex;
        wc = '{W0, W1};
        gc = '{G0, G1};
        din = '0;
        start = '0;
        ex = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset_strobe_dut%0d", s), strobe[s], 0);
            chk($sformatf("reset_busy_dut%0d", s), busy[s], 0);
            chk($sformatf("reset_valid_dut%0d", s), valid[s], 0);
            chk($sformatf("reset_dx_dut%0d", s), dx[s], 0);
            chk($sformatf("reset_dy_dut%0d", s), dy[s], 0);
            chk($sformatf("reset_btn_dut%0d", s), btn[s], 0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        frame(0, 16'($urandom), 2'($urandom), 1, 1, 0, 0, 1, 0, ex);
        frame(0, 16'h3CFE, 2'b10, 0, 1, 0, 0, 0, 0, ex);
        chk("fixed_dx", dx[0], 8'h3C);
        chk("fixed_dy", dy[0], 8'hFE);
        chk("fixed_btn", btn[0], 2'b01);
        for (int i = 0; i < 4; i++) begin
            frame(0, 16'($urandom), 2'($urandom), 1, 1, 0, i == 1, 0, 0, ex);
        end
        frame(0, 16'($urandom), 2'($urandom), 1, 1, 1, 0, 0, 0, ex);
        for (int i = 0; i < 2; i++) begin
            frame(0, 16'($urandom), 2'($urandom), 1, 0, 1, 0, 0,
                  ex + 4 * (W0 + 2) + G0 + 1, ex);
        end
        start[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            frame(1, 16'($urandom), 2'($urandom), 1, 1, 0, 0, 0, 0, ex);
        end
        repeat (4 * (W0 + 2) + G0 + 20) @(posedge clk);
        #1;
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
